lcg_ctrl: RTL and testbench

LCG_CTRL -- requirements
Module: lcg_ctrl

---
 rtl/lcg_pkg.sv | 20 ++
 rtl/lcg_modreduce.sv | 58 +++++
 rtl/lcg_ctrl.sv | 113 +++++++++++
 tb/tb_lcg_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcg_pkg.sv
// Shared types and constants for the LCG sequencer and its modular reducer.
package lcg_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    function automatic int reduce_cycles(input int w);
        return 2 * w + 1;
    endfunction

    localparam int REDUCE_CYCLES = reduce_cycles(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        REDUCE,
        OUT
    } state_t;

endpackage

// File: rtl/lcg_modreduce.sv
// Restoring shift-subtract reducer: r = p mod m, one dividend bit per cycle, MSB first.
module lcg_modreduce
    import lcg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PW    = REDUCE_CYCLES
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic             kill,
    input  logic [PW-1:0]    p,
    input  logic [WIDTH-1:0] m,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(PW + 1);

    logic [PW-1:0]    p_sh;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH:0]   rem_sh;
    logic [CW-1:0]    cnt;

    // rem < m always, so the shifted value fits WIDTH+1 bits and one subtract restores it.
    assign rem_sh  = {rem, p_sh[PW-1]};
    assign rem_nxt = (rem_sh >= {1'b0, m_q}) ? WIDTH'(rem_sh - {1'b0, m_q})
                                             : rem_sh[WIDTH-1:0];

    assign busy = (cnt != '0);
    // Asserted during the final iteration so the caller can leave on the same edge.
    assign done = (cnt == CW'(1));
    assign r    = rem;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p_sh <= '0;
            m_q  <= '0;
            rem  <= '0;
            cnt  <= '0;
        end else if (kill) begin
            cnt <= '0;
        end else if (load) begin
            p_sh <= p;
            m_q  <= m;
            rem  <= '0;
            cnt  <= CW'(PW);
        end else if (busy) begin
            p_sh <= p_sh << 1;
            rem  <= rem_nxt;
            cnt  <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/lcg_ctrl.sv
// LCG sequencer: emits count values of X(n+1) = (a*X(n) + c) mod m over a valid/ready port.
module lcg_ctrl
    import lcg_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic [WIDTH-1:0] MODULUS,
    input  logic [WIDTH-1:0] MULTIPLIER,
    input  logic [WIDTH-1:0] INCREMENT,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] next_value,
    output logic             done,
    output logic             err
);

    localparam int PW = reduce_cycles(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] m_q, a_q, c_q, x_q;
    logic [CNT_W-1:0] remaining;
    logic             done_q, err_q;
    logic [PW-1:0]    p_calc;
    logic             rd_load, rd_busy, rd_done;
    logic [WIDTH-1:0] rd_r;
    logic             start_ok, go, reject, kill, xfer, fin;

    // a*X + c < 2^(2*WIDTH+1), so the widened product never truncates.
    assign p_calc = PW'(a_q) * PW'(x_q) + PW'(c_q);

    assign start_ok = (state == IDLE) && start && (MODULUS != '0);
    assign go       = start_ok && (count != '0);
    assign reject   = (state == IDLE) && start && (MODULUS == '0);
    assign kill     = (state != IDLE) && abort;
    assign xfer     = (state == OUT) && out_ready && !abort;
    assign fin      = kill || (xfer && remaining == CNT_W'(1)) || (start_ok && count == '0);

    assign busy       = (state != IDLE);
    assign out_valid  = (state == OUT);
    assign next_value = out_valid ? rd_r : '0;
    assign done       = done_q;
    assign err        = err_q;

    lcg_modreduce #(.WIDTH(WIDTH), .PW(PW)) u_reduce (
        .CLK   (CLK),
        .RST_N (RST_N),
        .load  (rd_load),
        .kill  (kill),
        .p     (p_calc),
        .m     (m_q),
        .busy  (rd_busy),
        .done  (rd_done),
        .r     (rd_r)
    );

    always_comb begin
        state_nxt = state;
        rd_load   = 1'b0;
        unique case (state)
            IDLE:   if (go) state_nxt = CALC;
            CALC:   if (!rd_busy) begin
                        rd_load   = 1'b1;
                        state_nxt = REDUCE;
                    end
            REDUCE: if (rd_done) state_nxt = OUT;
            OUT:    if (out_ready) state_nxt = (remaining == CNT_W'(1)) ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
        // Abort outranks every other transition, including a same-cycle handshake.
        if (kill) begin
            state_nxt = IDLE;
            rd_load   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            c_q       <= '0;
            x_q       <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= fin;
            err_q  <= reject;
            if (go) begin
                m_q       <= MODULUS;
                a_q       <= MULTIPLIER;
                c_q       <= INCREMENT;
                x_q       <= seed;
                remaining <= count;
            end else if (xfer) begin
                x_q       <= rd_r;
                remaining <= remaining - CNT_W'(1);
            end else if (kill) begin
                remaining <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lcg_ctrl.sv
// Directed scoreboard bench for lcg_ctrl: expected values queued at issue, checked on each handshake.
module tb_lcg_ctrl;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  MODULUS = '0, MULTIPLIER = '0, INCREMENT = '0, seed = '0;
    logic [CW-1:0] count = '0;
    logic          busy, out_valid, done, err;
    logic [W-1:0]  next_value;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int xfers = 0;
    logic [W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    lcg_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .start      (start),
        .MODULUS    (MODULUS),
        .MULTIPLIER (MULTIPLIER),
        .INCREMENT  (INCREMENT),
        .seed       (seed),
        .count      (count),
        .abort      (abort),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .next_value (next_value),
        .done       (done),
        .err        (err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: every handshake consumes one queued expectation.
    always @(negedge CLK) begin
        if (RST_N && out_valid && out_ready) begin
            xfers++;
            chk("pending_exp", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("next_value", 64'(next_value), 64'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    // Returns just after the accept edge (counted as edge 1), then scrambles the inputs.
    task automatic start_run(input logic [W-1:0] m, input logic [W-1:0] a, input logic [W-1:0] c,
                             input logic [W-1:0] s, input logic [CW-1:0] n);
        MODULUS = m; MULTIPLIER = a; INCREMENT = c; seed = s; count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        edge_n = 1;
        MODULUS = 32'h1234_5677; MULTIPLIER = 32'hdead_beef; INCREMENT = 32'h0bad_f00d;
        seed = 32'hffff_0001; count = 16'd77;
    endtask

    task automatic wait_valid(input int exp_edge, input string name);
        int g = 0;
        while (!out_valid && g < 400) begin
            tick();
            g++;
        end
        chk(name, 64'(edge_n), 64'(exp_edge));
    endtask

    task automatic wait_done(input string name);
        int g = 0;
        while (!done && g < 1000) begin
            tick();
            g++;
        end
        chk(name, 64'(done), 64'd1);
        chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int x0;
        logic seen;

        #11;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_value", 64'(next_value), 0);
        #1 RST_N = 1'b1;

        // Two-value run, accepted on the first edge after reset release
        out_ready = 1'b1;
        exp_q.push_back(32'd444307);
        exp_q.push_back(32'd466569);
        start_run(32'd993441, 32'd4001, 32'd60211, 32'd96, 16'd2);
        chk("accept_first_edge", 64'(busy), 1);
        wait_valid(67, "lat_first");
        tick();
        wait_valid(134, "lat_second");
        tick();
        chk("done_after_2", 64'(done), 1);
        chk("idle_after_2", 64'(busy), 0);
        tick();
        chk("done_one_cycle", 64'(done), 0);

        // Back-pressure: value must hold for 10 cycles
        out_ready = 1'b0;
        exp_q.push_back(32'd444307);
        start_run(32'd993441, 32'd4001, 32'd60211, 32'd96, 16'd1);
        wait_valid(67, "lat_hold");
        x0 = xfers;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_value", 64'(next_value), 64'd444307);
            tick();
        end
        chk("hold_no_xfer", 64'(xfers - x0), 0);
        out_ready = 1'b1;
        tick();
        chk("hold_one_xfer", 64'(xfers - x0), 1);
        chk("hold_done", 64'(done), 1);
        tick();

        // m == 0 rejected
        start_run(32'd0, 32'd3, 32'd4, 32'd5, 16'd2);
        chk("err_pulse", 64'(err), 1);
        chk("err_busy", 64'(busy), 0);
        chk("err_valid", 64'(out_valid), 0);
        chk("err_done", 64'(done), 0);
        tick();
        chk("err_one_cycle", 64'(err), 0);
        chk("err_still_idle", 64'(busy), 0);

        // count == 0: done only
        start_run(32'd993441, 32'd4001, 32'd60211, 32'd96, 16'd0);
        chk("cnt0_done", 64'(done), 1);
        chk("cnt0_busy", 64'(busy), 0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("cnt0_no_valid", 64'(seen), 0);

        // m == 1 yields zeros
        repeat (3) exp_q.push_back(32'd0);
        start_run(32'd1, 32'd5, 32'd3, 32'd9, 16'd3);
        wait_done("m1_done");
        tick();

        // seed >= m, small modulus: 34%7=6, 22%7=1, 7%7=0
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        start_run(32'd7, 32'd3, 32'd4, 32'd10, 16'd3);
        wait_done("m7_done");
        tick();

        // Full-width operands: (2^32-1)*2^32 mod (2^32-5) = 25-5 = 20
        exp_q.push_back(32'd20);
        start_run(32'hffff_fffb, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 16'd1);
        wait_done("wide_done");
        tick();

        // Abort in REDUCE cycle 30
        start_run(32'd993441, 32'd4001, 32'd60211, 32'd96, 16'd2);
        repeat (30) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_valid", 64'(out_valid), 0);
        chk("abort_done", 64'(done), 1);
        x0 = xfers;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_output", 64'(seen), 0);
        chk("abort_no_xfer", 64'(xfers - x0), 0);
        exp_q.push_back(32'd444307);
        start_run(32'd993441, 32'd4001, 32'd60211, 32'd96, 16'd1);
        wait_valid(67, "lat_after_abort");
        wait_done("restart_done");
        tick();

        // Asynchronous reset while in OUT, then rerun
        out_ready = 1'b0;
        exp_q.push_back(32'd444307);
        start_run(32'd993441, 32'd4001, 32'd60211, 32'd96, 16'd1);
        wait_valid(67, "lat_pre_reset");
        tick();
        #3 RST_N = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 0);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_value", 64'(next_value), 0);
        chk("arst_done", 64'(done), 0);
        chk("arst_err", 64'(err), 0);
        exp_q.delete();
        @(posedge CLK);
        #3 RST_N = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(32'd444307);
        start_run(32'd993441, 32'd4001, 32'd60211, 32'd96, 16'd1);
        wait_valid(67, "lat_after_reset");
        wait_done("rerun_done");
        tick();

        chk("total_xfers", 64'(xfers), 64'd12);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
